// File: rtl/bus_src_pkg.sv
// bus_src_pkg: shared source-code constants, FSM state encoding and the
// unmapped-code predicate for the bus source selector.
package bus_src_pkg;

  localparam logic [3:0] SEL_SP  = 4'h1;
  localparam logic [3:0] SEL_MEM = 4'h2;
  localparam logic [3:0] SEL_IMM = 4'h3;
  localparam logic [3:0] SEL_MAR = 4'h4;
  localparam logic [3:0] SEL_MDR = 4'h5;
  localparam logic [3:0] SEL_PR1 = 4'h6;
  localparam logic [3:0] SEL_PR2 = 4'h7;
  localparam logic [3:0] SEL_PR3 = 4'h8;
  localparam logic [3:0] SEL_COL = 4'h9;
  localparam logic [3:0] SEL_ROW = 4'hA;
  localparam logic [3:0] SEL_R1  = 4'hB;
  localparam logic [3:0] SEL_R2  = 4'hC;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DRIVE    = 2'd2
  } state_t;

  // Codes 0000 and 1101-1111 have no source behind them.
  function automatic logic is_unmapped(input logic [3:0] code);
    return (code == 4'h0) || (code > SEL_R2);
  endfunction

endpackage

// File: rtl/bus_src_mem_wait.sv
// bus_src_mem_wait: data-memory read handshake. Raises mem_rd_req on start,
// captures mem_data on mem_ready, or aborts after MEM_TIMEOUT wait edges.
// done/err are single-cycle indications to the owning FSM; ready beats timeout.
module bus_src_mem_wait #(
  parameter int DATA_W      = 8,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_rd_req,
  output logic [DATA_W-1:0] hold_reg,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;
  logic             timeout_hit;

  // The edge that would take the counter to MEM_TIMEOUT is the abort edge.
  assign timeout_hit = (cnt == CNT_LAST);
  assign done        = mem_rd_req & (mem_ready | timeout_hit);
  assign err         = mem_rd_req & ~mem_ready & timeout_hit;

  // Request, wait counter and captured read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_rd_req <= 1'b0;
      cnt        <= '0;
      hold_reg   <= '0;
    end else if (start) begin
      mem_rd_req <= 1'b1;
      cnt        <= '0;
    end else if (mem_rd_req) begin
      if (mem_ready) begin
        hold_reg   <= mem_data;
        mem_rd_req <= 1'b0;
        cnt        <= '0;
      end else if (timeout_hit) begin
        hold_reg   <= '0;
        mem_rd_req <= 1'b0;
        cnt        <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/bus_source_select.sv
// bus_source_select: latches a source code on EN_OP and drives the chosen
// register, memory read data or immediate onto a registered bus.
// Optional macro BUS_SRC_ILLEGAL_CHK_EN: reject unmapped codes (illegal_sel).
//
// state     | meaning
// ST_IDLE   | no source selected, bus held at 0
// ST_MEM_WAIT | memory read outstanding, bus held at 0, EN_OP ignored
// ST_DRIVE  | bus follows the latched source, gated by EN_OUT
module bus_source_select
  import bus_src_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        sel,
  input  logic              EN_OP,
  input  logic              EN_OUT,
  input  logic [DATA_W-1:0] src_sp,
  input  logic [DATA_W-1:0] src_mar,
  input  logic [DATA_W-1:0] src_mdr,
  input  logic [DATA_W-1:0] src_pr1,
  input  logic [DATA_W-1:0] src_pr2,
  input  logic [DATA_W-1:0] src_pr3,
  input  logic [DATA_W-1:0] src_col,
  input  logic [DATA_W-1:0] src_row,
  input  logic [DATA_W-1:0] src_r1,
  input  logic [DATA_W-1:0] src_r2,
  input  logic [DATA_W-1:0] src_imm,
  output logic              mem_rd_req,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_valid,
  output logic              busy,
  output logic              mem_err,
  output logic              illegal_sel
);

  state_t            state;
  logic [3:0]        src_reg;
  logic [DATA_W-1:0] src_val;
  logic [DATA_W-1:0] hold_reg;
  logic              mem_start;
  logic              mem_done;
  logic              mem_abort;

  assign busy      = (state == ST_MEM_WAIT);
  assign mem_start = (state != ST_MEM_WAIT) && EN_OP && (sel == SEL_MEM);

  bus_src_mem_wait #(
    .DATA_W      (DATA_W),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_mem_wait (
    .clk        (clk),
    .rst        (rst),
    .start      (mem_start),
    .mem_ready  (mem_ready),
    .mem_data   (mem_data),
    .mem_rd_req (mem_rd_req),
    .hold_reg   (hold_reg),
    .done       (mem_done),
    .err        (mem_abort)
  );

  // Register sources are sampled live; memory uses the captured read data.
  always_comb begin
    src_val = '0;
    case (src_reg)
      SEL_SP:  src_val = src_sp;
      SEL_MEM: src_val = hold_reg;
      SEL_IMM: src_val = src_imm;
      SEL_MAR: src_val = src_mar;
      SEL_MDR: src_val = src_mdr;
      SEL_PR1: src_val = src_pr1;
      SEL_PR2: src_val = src_pr2;
      SEL_PR3: src_val = src_pr3;
      SEL_COL: src_val = src_col;
      SEL_ROW: src_val = src_row;
      SEL_R1:  src_val = src_r1;
      SEL_R2:  src_val = src_r2;
      default: src_val = '0;
    endcase
  end

`ifndef BUS_SRC_ILLEGAL_CHK_EN
  assign illegal_sel = 1'b0;
`endif

  // Control FSM with registered bus outputs and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      src_reg   <= 4'h0;
      bus_out   <= '0;
      bus_valid <= 1'b0;
      mem_err   <= 1'b0;
`ifdef BUS_SRC_ILLEGAL_CHK_EN
      illegal_sel <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DRIVE: begin
          if (state == ST_DRIVE) begin
            bus_out   <= EN_OUT ? src_val : '0;
            bus_valid <= EN_OUT;
          end else begin
            bus_out   <= '0;
            bus_valid <= 1'b0;
          end
          if (EN_OP) begin
            mem_err <= 1'b0;
`ifdef BUS_SRC_ILLEGAL_CHK_EN
            if (is_unmapped(sel)) begin
              illegal_sel <= 1'b1;
              state       <= ST_IDLE;
            end else begin
              illegal_sel <= 1'b0;
              src_reg     <= sel;
              state       <= (sel == SEL_MEM) ? ST_MEM_WAIT : ST_DRIVE;
            end
`else
            src_reg <= sel;
            state   <= (sel == SEL_MEM) ? ST_MEM_WAIT : ST_DRIVE;
`endif
          end
        end
        ST_MEM_WAIT: begin
          bus_out   <= '0;
          bus_valid <= 1'b0;
          if (mem_done) begin
            state   <= ST_DRIVE;
            mem_err <= mem_abort;
          end
        end
        default: begin
          state     <= ST_IDLE;
          bus_out   <= '0;
          bus_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
